// File: rtl/output_forward_mac.sv
// -----------------------------------------------------------------------------
// output_forward_mac
//   Forward-pass output neuron. It takes N_HIDDEN (hidden_val, weight) pairs
//   over a valid/ready handshake, forms each unsigned product, and adds it into a
//   saturating accumulator. At the end of a pass it publishes the registered sum
//   on final_o, together with a one-cycle done_o pulse.
//
//   Optional feature macro: OUTPUT_BIAS_EN
//     defined   : adds port bias_i. The accumulator starts from the zero-extended
//                 bias_i value sampled on the start_i cycle.
//     undefined : there is no bias_i port and the accumulator starts from zero.
//
// Ports
//   clk_i         in   1          clock; all state changes on the rising edge
//   rst_i         in   1          asynchronous reset, active-high
//   clear_i       in   1          synchronous clear: return to idle, zero final_o
//   start_i       in   1          begin a pass (only honoured while idle)
//   hid_valid_i   in   1          hidden_val_i / w_i pair is valid
//   hid_ready_o   out  1          pair is accepted this cycle (accumulating)
//   hidden_val_i  in   HID_W      hidden neuron activation (unsigned)
//   w_i           in   W_W        matching output weight (unsigned)
//   bias_i        in   W_W        initial accumulator value (OUTPUT_BIAS_EN only)
//   idx_o         out  IDX_W      index of the pair expected next
//   busy_o        out  1          high while accumulating
//   done_o        out  1          one-cycle pulse; final_o holds the new sum
//   final_o       out  ACC_W      registered neuron sum
//   ovf_o         out  1          sticky for each pass: saturation occurred
// -----------------------------------------------------------------------------
module output_forward_mac #(
  parameter int N_HIDDEN = 4,
  parameter int HID_W    = 10,
  parameter int W_W      = 8,
  parameter int ACC_W    = 23,
  localparam int IDX_W   = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic             hid_valid_i,
  output logic             hid_ready_o,
  input  logic [HID_W-1:0] hidden_val_i,
  input  logic [W_W-1:0]   w_i,
`ifdef OUTPUT_BIAS_EN
  input  logic [W_W-1:0]   bias_i,
`endif
  output logic [IDX_W-1:0] idx_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [ACC_W-1:0] final_o,
  output logic             ovf_o
);

  localparam int PROD_W = HID_W + W_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_HIDDEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Adds the product to the accumulator at ACC_W+1 bits and clamps on carry-out.
  // The return value is {overflow_flag, clamped_sum}. Once the accumulator is at
  // full scale, any non-zero product carries out again, so saturation persists.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] acc,
                                             input logic [PROD_W-1:0] prod);
    logic [ACC_W:0] sum;
    sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    if (sum[ACC_W]) begin
      sat_add = {1'b1, {ACC_W{1'b1}}};
    end else begin
      sat_add = sum;
    end
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [ACC_W-1:0]   acc_r;
  logic [IDX_W-1:0]   idx_r;
  logic [ACC_W-1:0]   final_r;
  logic               done_r;
  logic               ovf_r;

  logic               ready_s;
  logic               busy_s;
  logic               xfer_s;
  logic               last_s;
  logic [PROD_W-1:0]  prod_s;
  logic [ACC_W:0]     sat_s;
  logic [ACC_W-1:0]   init_s;

  assign xfer_s = hid_valid_i && ready_s;
  assign last_s = (idx_r == LAST_IDX);
  assign prod_s = PROD_W'(hidden_val_i) * PROD_W'(w_i);
  assign sat_s  = sat_add(acc_r, prod_s);

`ifdef OUTPUT_BIAS_EN
  assign init_s = {{(ACC_W - W_W){1'b0}}, bias_i};
`else
  assign init_s = {ACC_W{1'b0}};
`endif

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; clear_i overrides both start_i and a pending transfer.
  always_comb begin
    state_nxt_s = state_r;
    if (clear_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            state_nxt_s = ST_ACCUM;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (xfer_s && last_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_ACCUM;
          end
        end
        ST_DONE: begin
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // FSM output decode: the handshake is open only while accumulating.
  always_comb begin
    ready_s = 1'b0;
    busy_s  = 1'b0;
    case (state_r)
      ST_ACCUM: begin
        ready_s = 1'b1;
        busy_s  = 1'b1;
      end
      ST_IDLE, ST_DONE: begin
        ready_s = 1'b0;
        busy_s  = 1'b0;
      end
      default: begin
        ready_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Datapath: accumulator, pair index, published result, done pulse, and sticky overflow.
  // final_o and done_o are loaded on the last transfer edge. As a result, the done_o
  // cycle already shows the new sum to the consumer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_r   <= {ACC_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      final_r <= {ACC_W{1'b0}};
      done_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (clear_i) begin
      acc_r   <= {ACC_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      final_r <= {ACC_W{1'b0}};
      done_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            acc_r <= init_s;
            idx_r <= {IDX_W{1'b0}};
            ovf_r <= 1'b0;
          end
        end
        ST_ACCUM: begin
          if (xfer_s) begin
            acc_r <= sat_s[ACC_W-1:0];
            ovf_r <= ovf_r | sat_s[ACC_W];
            if (last_s) begin
              idx_r   <= {IDX_W{1'b0}};
              final_r <= sat_s[ACC_W-1:0];
              done_r  <= 1'b1;
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          idx_r <= {IDX_W{1'b0}};
        end
        default: begin
          idx_r <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

  assign hid_ready_o = ready_s;
  assign busy_o      = busy_s;
  assign idx_o       = idx_r;
  assign done_o      = done_r;
  assign final_o     = final_r;
  assign ovf_o       = ovf_r;

endmodule
